// File: rtl/addr_seq_pkg.sv
// Shared encodings for the address sequencer: configuration modes and controller states.
package addr_seq_pkg;

   localparam logic [1:0] MODE_WRAP        = 2'd0;
   localparam logic [1:0] MODE_ONESHOT     = 2'd1;
   localparam logic [1:0] MODE_PINGPONG    = 2'd2;
   localparam logic [1:0] MODE_ONESHOT_ALT = 2'd3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/addr_step_calc.sv
// Combinational step: next address in the current direction, end-of-range detection,
// and the clamped address used when a ping-pong sweep turns around.
module addr_step_calc #(
   parameter int ADDR_W = 8
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W-1:0] limit,
   input  logic [ADDR_W-1:0] stride,
   input  logic              dir_down,
   output logic [ADDR_W-1:0] next_addr,
   output logic              end_of_range,
   output logic [ADDR_W-1:0] turn_addr
);

   logic [ADDR_W:0]   sum;
   logic [ADDR_W:0]   diff;
   logic              up_end;
   logic              down_end;
   logic [ADDR_W-1:0] turn_from_top;
   logic [ADDR_W-1:0] turn_from_bottom;

   // One extra bit keeps the carry (up) and the borrow (down) visible.
   always_comb begin
      sum              = {1'b0, addr} + {1'b0, stride};
      diff             = {1'b0, addr} - {1'b0, stride};
      up_end           = (sum > {1'b0, limit});
      down_end         = diff[ADDR_W] || (diff[ADDR_W-1:0] < base);
      turn_from_top    = down_end ? base  : diff[ADDR_W-1:0];
      turn_from_bottom = up_end   ? limit : sum[ADDR_W-1:0];
      if (dir_down) begin
         next_addr    = diff[ADDR_W-1:0];
         end_of_range = down_end;
         turn_addr    = turn_from_bottom;
      end else begin
         next_addr    = sum[ADDR_W-1:0];
         end_of_range = up_end;
         turn_addr    = turn_from_top;
      end
   end

endmodule

// File: rtl/addr_sequencer.sv
// Address sequencer: walks a latched [base, limit] range with a fixed stride in
// wrap, one-shot or ping-pong fashion, advancing on a valid/ready handshake.
module addr_sequencer
   import addr_seq_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int STRIDE_W = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   input  logic [ADDR_W-1:0]   cfg_base,
   input  logic [ADDR_W-1:0]   cfg_limit,
   input  logic [STRIDE_W-1:0] cfg_stride,
   input  logic [1:0]          cfg_mode,
   input  logic                addr_ready,
   output logic [ADDR_W-1:0]   addr,
   output logic                addr_valid,
   output logic                busy,
   output logic                done,
   output logic                wrap
);

   state_t                state_q, state_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic                  dir_q, dir_d;
   logic                  done_q, done_d;
   logic                  wrap_q, wrap_d;
   logic [ADDR_W-1:0]     base_q, base_d;
   logic [ADDR_W-1:0]     limit_q, limit_d;
   logic [STRIDE_W-1:0]   stride_q, stride_d;
   logic [1:0]            mode_q, mode_d;

   logic [ADDR_W-1:0]     eff_limit;
   logic [ADDR_W-1:0]     eff_stride;
   logic [ADDR_W-1:0]     next_addr;
   logic                  end_of_range;
   logic [ADDR_W-1:0]     turn_addr;

   // Degenerate configurations are normalised on use so the latched copy stays raw.
   assign eff_limit  = (limit_q < base_q) ? base_q : limit_q;
   assign eff_stride = (stride_q == '0) ? ADDR_W'(1) : ADDR_W'(stride_q);

   addr_step_calc #(
      .ADDR_W (ADDR_W)
   ) u_step (
      .addr         (addr_q),
      .base         (base_q),
      .limit        (eff_limit),
      .stride       (eff_stride),
      .dir_down     (dir_q),
      .next_addr    (next_addr),
      .end_of_range (end_of_range),
      .turn_addr    (turn_addr)
   );

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      dir_d    = dir_q;
      done_d   = 1'b0;
      wrap_d   = 1'b0;
      base_d   = base_q;
      limit_d  = limit_q;
      stride_d = stride_q;
      mode_d   = mode_q;
      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               state_d  = ST_RUN;
               addr_d   = cfg_base;
               dir_d    = 1'b0;
               base_d   = cfg_base;
               limit_d  = cfg_limit;
               stride_d = cfg_stride;
               mode_d   = cfg_mode;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else if (addr_ready) begin
               if (!end_of_range) begin
                  addr_d = next_addr;
               end else begin
                  case (mode_q)
                     MODE_WRAP: begin
                        addr_d = base_q;
                        wrap_d = 1'b1;
                     end
                     MODE_PINGPONG: begin
                        addr_d = turn_addr;
                        dir_d  = ~dir_q;
                        wrap_d = 1'b1;
                     end
                     default: begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                     end
                  endcase
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         dir_q    <= 1'b0;
         done_q   <= 1'b0;
         wrap_q   <= 1'b0;
         base_q   <= '0;
         limit_q  <= '0;
         stride_q <= '0;
         mode_q   <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         dir_q    <= dir_d;
         done_q   <= done_d;
         wrap_q   <= wrap_d;
         base_q   <= base_d;
         limit_q  <= limit_d;
         stride_q <= stride_d;
         mode_q   <= mode_d;
      end
   end

   assign addr       = addr_q;
   assign addr_valid = (state_q == ST_RUN);
   assign busy       = (state_q == ST_RUN);
   assign done       = done_q;
   assign wrap       = wrap_q;

endmodule
